vga_scan_controller: RTL
========================

# vga_scan_controller

Scan-side counterpart of the video pixel encoder. Generates the 640x480@60 Hz raster and drives the current pixel coordinate `x`/`y` into the encoder. It samples the encoder's 1-bit `px_data` and produces registered VGA `hsync`, `vsync` and 12-bit RGB. It also gives game logic a per-frame strobe.

## Interface
- `DIV`, 4: system clocks per pixel; legal range ≥2, so 100 MHz `clk` gives a 25 MHz pixel rate.
- `FG_RGB`, 12'hFFF: colour for `px_data`=1 inside the active area.
- `BG_RGB`, 12'h000: colour for `px_data`=0 inside the active area.
- `clk` input 1: system clock, the design's only clock.
- `rst` input 1: synchronous, active-high reset.
- `px_data` input 1: pixel bit from the encoder. It is registered there, so it is valid 1 `clk` after `x`/`y` change.
- `x` output 11: horizontal counter, 0..799.
- `y` output 11: vertical counter, 0..524.
- `hsync` output 1: horizontal sync, active-low.
- `vsync` output 1: vertical sync, active-low.
- `rgb` output 12: colour, {R[3:0],G[3:0],B[3:0]}.
- `blank` output 1: 1 outside the 640x480 active area.
- `frame_start` output 1: one-`clk` pulse at each frame wrap.

## Operation
- **Divider.** `div_cnt` counts 0..DIV-1 and wraps. `tick` = (`div_cnt`==DIV-1).
- **Horizontal counter.** On `tick`, `x` increments. At 799, `x` wraps to 0 and `y` increments.
- **Vertical counter.** At `y`=524 together with `x`=799, `y` wraps to 0.
- **Counter stability.** `x` and `y` change only on `tick`, so each coordinate is held for DIV `clk` cycles.
- **Horizontal timing.** Active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- **Vertical timing.** Active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- **Sampling point.** On `tick`, the block samples `px_data` together with the decode of the pre-increment `x`/`y`. By then `px_data` has had DIV-1 ≥ 1 cycles to settle.
- **Registered outputs, updated on `tick` only:**
  - `hsync` = !(656 ≤ x ≤ 751)
  - `vsync` = !(490 ≤ y ≤ 491)
  - `blank` = !(x<640 && y<480)
  - `rgb` = blank ? 12'h000 : (px_data ? FG_RGB : BG_RGB)
- **Outside the active area.** `rgb` is forced to 0 regardless of `px_data`.
- **Frame strobe.** `frame_start` = 1 for exactly the `clk` after the `tick` on which (x,y) goes (799,524)→(0,0). It is 0 otherwise.
- **Reset values.** `div_cnt`=0, `x`=0, `y`=0, `hsync`=1, `vsync`=1, `blank`=1, `rgb`=0, `frame_start`=0.
- **Reset mid-operation.** Reset mid-line or mid-frame restarts the raster at (0,0) on the next `clk`. No partial-state carry-over.
- **Counter range.** `x` and `y` never leave 0..799 and 0..524.

## Timing
- **Update cadence.** `x`/`y` update 1 `clk` after `tick`; period is DIV `clk` per pixel.
- **Video latency.** Video outputs (`hsync`, `vsync`, `blank`, `rgb`) lag the `x`/`y` they describe by one pixel period. All four are aligned with each other.
- **Line and frame length.** Line = 800·DIV `clk`; frame = 420000·DIV `clk`.
- **Frame strobe timing.** `frame_start` rises 1 `clk` after the wrap tick and lasts 1 `clk`.
- **First `tick`.** Occurs DIV `clk` after reset deasserts.
- **Reset exit.** Outputs hold their reset values until the first `tick`.
- **Simultaneous events.** Reset overrides `tick`.
- **Width rules.** Comparisons use 11-bit unsigned arithmetic; no wrap below 0 is possible.

## Structure
- **Shared package `vga_pkg`:**
  - Constants H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800.
  - Constants V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525.
  - Coordinate width 11, RGB width 12.
- **Sub-module `pixel_tick_gen`.** Parameter DIV; ports `clk`, `rst`, `tick`. The remaining counter and output logic stays in the top module.

## Test plan
1. **Reset and first tick.** Hold `rst` for 3 `clk` at DIV=4, then release.
   - `x`=`y`=0, `hsync`=`vsync`=`blank`=1, `rgb`=0 until the first `tick`.
   - `x`=1 exactly 4 `clk` after release.
2. **Line wrap.** Run 800 ticks.
   - `x` goes 799→0 and `y` goes 0→1 on the same `clk`.
   - Line period = 3200 `clk`.
3. **Sync widths.** Over one frame:
   - `hsync` low for exactly 96 ticks per line, first low on the tick after `x`=656 is presented.
   - `vsync` low for exactly 2 lines (y=490,491).
4. **Colour gating.** Drive `px_data`=1 constantly with FG_RGB=12'hFFF.
   - `rgb`=FFF for sampled x=639,y=0; `rgb`=000 for x=640.
   - `rgb`=000 for y=480 at any x.
   - `px_data`=0 at x=10 gives BG_RGB.
5. **Frame strobe.** Run 2 frames.
   - `frame_start` pulses exactly twice, 1 `clk` wide, 1680000 `clk` apart at DIV=4.
6. **Reset mid-operation.** Assert `rst` at x=400,y=200.
   - Next `clk`: all outputs at reset values.
   - After release the raster restarts from (0,0) with correct timing.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz raster constants, coordinate/colour types and timing decodes.
package vga_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned RGB_W   = 12;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = 800;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = 525;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0]   rgb_t;

  localparam coord_t H_ACT_END    = coord_t'(H_ACTIVE);
  localparam coord_t H_SYNC_FIRST = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);

  localparam coord_t V_ACT_END    = coord_t'(V_ACTIVE);
  localparam coord_t V_SYNC_FIRST = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);

  function automatic logic in_hsync(input coord_t x);
    return (x >= H_SYNC_FIRST) && (x <= H_SYNC_LAST);
  endfunction

  function automatic logic in_vsync(input coord_t y);
    return (y >= V_SYNC_FIRST) && (y <= V_SYNC_LAST);
  endfunction

  function automatic logic in_active(input coord_t x, input coord_t y);
    return (x < H_ACT_END) && (y < V_ACT_END);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate enable: one-clk tick every DIV system clocks (DIV >= 2).
module pixel_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster scanner: drives x/y to the pixel encoder and registers sync, blank and colour.
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int unsigned DIV    = 4,
  parameter logic [11:0] FG_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        px_data,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        blank,
  output logic        frame_start
);

  logic tick;
  logic x_wrap;
  logic y_wrap;
  logic active;

  pixel_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    x_wrap = (x == H_LAST);
    y_wrap = (y == V_LAST);
    active = in_active(x, y);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (tick) begin
      if (x_wrap) begin
        x <= '0;
        y <= y_wrap ? '0 : y + coord_t'(1);
      end else begin
        x <= x + coord_t'(1);
      end
    end
  end

  // Video decode uses the pre-increment x/y, so outputs trail the coordinate by one pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank       <= 1'b1;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && x_wrap && y_wrap;
      if (tick) begin
        hsync <= !in_hsync(x);
        vsync <= !in_vsync(y);
        blank <= !active;
        rgb   <= active ? (px_data ? FG_RGB : BG_RGB) : '0;
      end
    end
  end

endmodule
